riscv_dmem_responder: RTL
=========================

Name: riscv_dmem_responder

Overview:
- Data-memory responder that serves the core's data port: accepts load/store requests over a val/rdy request channel and returns responses over a val/rdy response channel.
- Latency is one cycle, with backpressure absorbed by a 2-entry response queue.
- Load data is returned right-justified; the requester does sign/zero extension.
- Used as the behavioural dmem behind the pipelined core in test harnesses, and as the template for the cache-side responder.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words in the backing array (power of two).
- BASE_ADDR, 32'h00000000, byte address that maps to word 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- memreq_val  in  1  request valid
- memreq_rdy  out  1  request ready
- memreq_msg_type  in  1  0 = read, 1 = write
- memreq_msg_len  in  2  0 = word, 1 = byte, 2 = half, 3 = treated as word
- memreq_msg_addr  in  32  byte address
- memreq_msg_data  in  32  store data, right-justified
- memresp_val  out  1  response valid
- memresp_rdy  in  1  response ready
- memresp_msg_type  out  1  echo of request type
- memresp_msg_len  out  2  echo of request len
- memresp_msg_data  out  32  load data right-justified, zero-filled above len; 0 for writes
- err  out  1  sticky error flag

Behaviour:
- Clock and reset: clk, single clock domain; reset, synchronous, active-high.
- Reset values:
  - memreq_rdy = 0 while reset is high.
  - memresp_val = 0; memresp_msg_* = 0; err = 0.
  - Queue count = 0; head and tail pointers = 0.
  - Memory array is NOT reset.
- Handshakes:
  - Request fires when memreq_val && memreq_rdy.
  - Response fires when memresp_val && memresp_rdy.
  - memreq_rdy = !reset && (count != 2). No combinational path from memresp_rdy to memreq_rdy.
- Latency:
  - A request fired in cycle t has its response at the queue head (or behind older entries) from cycle t+1.
  - With memresp_rdy held high, throughput is 1 request/cycle and count stays at 1.
- Address decode:
  - off = addr - BASE_ADDR; word index = off[31:2]; lane = off[1:0].
  - Out of range (off >= 4*MEM_WORDS, unsigned, which also covers addr < BASE_ADDR): read returns 0, write is dropped, err set.
- Alignment:
  - Half with lane[0] = 1, or word with lane != 0, sets err.
  - The access is still performed with lane forced down to the natural alignment (half: lane & 2; word: 0).
- Read data:
  - byte: {24'b0, word[8*lane +: 8]}
  - half: {16'b0, word[16*lane[1] +: 16]}
  - word: full word.
  - Read value is captured at the firing edge from pre-write array contents. Only one request fires per cycle, so no same-cycle RAW exists.
- Write:
  - Updates only the addressed byte lanes at the firing edge, using the low bytes of memreq_msg_data (byte: data[7:0]; half: data[15:0]).
  - A read fired in the next cycle to the same word observes the new data.
- Response queue:
  - 2-entry circular FIFO holding {type, len, data}.
  - Enqueue on request fire; dequeue on response fire.
  - Simultaneous enqueue + dequeue at count 1 leaves count at 1; at count 2 enqueue cannot occur.
  - memresp_val = (count != 0); memresp_msg_* driven from the head entry; zeros when empty.
- err:
  - Set on any out-of-range or misaligned fire; cleared only by reset.
  - Never blocks traffic.
- Reset mid-operation: queued responses are discarded; writes already fired remain in the array.
- Count arithmetic: 2-bit count, never exceeds 2; pointers are 1 bit and wrap.

Test Plan:
1. Word round trip: write addr 0x100, data 0xDEADBEEF, len 0, then read 0x100 back-to-back with memresp_rdy = 1 -> write response data 0 at t+1; read response 0xDEADBEEF at t+2.
2. Subword: after test 1, byte read at 0x103 -> 0x000000DE; half read at 0x102 -> 0x0000DEAD; byte write 0x55 to 0x101, then word read -> 0xDEAD55EF.
3. Backpressure: memresp_rdy = 0 and 3 reads issued -> first two accepted, memreq_rdy falls to 0 after the second; raise memresp_rdy -> responses drain in order and the third request is accepted the cycle after the first dequeue.
4. Throughput: 16 consecutive reads with memresp_rdy = 1 -> one response per cycle, count never exceeds 1, memreq_rdy is never low.
5. Errors: half read at 0x101 -> err = 1, data from lane 0; write to BASE_ADDR + 4*MEM_WORDS -> dropped, err stays 1; read of word 0 is unaffected.
6. Reset mid-operation: two responses queued, assert reset for 1 cycle -> memresp_val = 0, err = 0, memreq_rdy = 0 during reset, 1 after; a subsequent read returns data written before reset.

Source files
------------

// File: rtl/riscv_dmem_responder.sv
// Behavioural data memory: one-cycle load/store responses via a 2-entry response queue;
// requests stall (memreq_rdy low) only while the queue is full, independent of memresp_rdy.
module riscv_dmem_responder #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic        memreq_msg_type,
    input  logic [1:0]  memreq_msg_len,
    input  logic [31:0] memreq_msg_addr,
    input  logic [31:0] memreq_msg_data,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic        memresp_msg_type,
    output logic [1:0]  memresp_msg_len,
    output logic [31:0] memresp_msg_data,
    output logic        err
);
    localparam int          AW    = $clog2(MEM_WORDS);
    localparam logic [32:0] LIMIT = 33'(MEM_WORDS) * 33'd4;

    logic [31:0] mem_q [MEM_WORDS];

    logic        q_type_q [2];
    logic [1:0]  q_len_q  [2];
    logic [31:0] q_data_q [2];
    logic [1:0]  count_q, count_d;
    logic        head_q, tail_q;
    logic        err_q, err_d;

    logic        req_fire, resp_fire;
    logic [31:0] off;
    logic        in_range, misalign;
    logic [1:0]  lane, lane_a;
    logic [AW-1:0] idx;
    logic [31:0] rword, rdata, resp_data;
    logic [3:0]  be;
    logic [31:0] wdata;

    assign memreq_rdy = !reset && (count_q != 2'd2);
    assign req_fire   = memreq_val && memreq_rdy;
    assign resp_fire  = memresp_val && memresp_rdy;

    // Unsigned compare of the offset also rejects addresses below BASE_ADDR.
    assign off      = memreq_msg_addr - BASE_ADDR;
    assign in_range = ({1'b0, off} < LIMIT);
    assign idx      = off[AW+1:2];
    assign lane     = off[1:0];
    assign rword    = mem_q[idx];

    always_comb begin
        lane_a   = 2'd0;
        misalign = 1'b0;
        be       = 4'b1111;
        wdata    = memreq_msg_data;
        rdata    = rword;
        case (memreq_msg_len)
            2'd1: begin
                lane_a = lane;
                be     = 4'b0001 << lane;
                wdata  = {4{memreq_msg_data[7:0]}};
                rdata  = {24'b0, rword[{lane, 3'b000} +: 8]};
            end
            2'd2: begin
                lane_a   = {lane[1], 1'b0};
                misalign = lane[0];
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{memreq_msg_data[15:0]}};
                rdata    = {16'b0, rword[{lane[1], 4'b0000} +: 16]};
            end
            default: begin
                misalign = (lane != 2'd0);
            end
        endcase
    end

    assign resp_data = (!memreq_msg_type && in_range) ? rdata : 32'd0;
    assign count_d   = count_q + {1'b0, req_fire} - {1'b0, resp_fire};
    assign err_d     = err_q || (req_fire && (!in_range || misalign));

    always_ff @(posedge clk) begin
        if (req_fire && memreq_msg_type && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_type_q[i] <= 1'b0;
                q_len_q[i]  <= 2'd0;
                q_data_q[i] <= 32'd0;
            end
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
            if (req_fire) begin
                q_type_q[tail_q] <= memreq_msg_type;
                q_len_q[tail_q]  <= memreq_msg_len;
                q_data_q[tail_q] <= resp_data;
                tail_q           <= ~tail_q;
            end
            if (resp_fire) head_q <= ~head_q;
        end
    end

    assign memresp_val      = (count_q != 2'd0);
    assign memresp_msg_type = memresp_val ? q_type_q[head_q] : 1'b0;
    assign memresp_msg_len  = memresp_val ? q_len_q[head_q]  : 2'd0;
    assign memresp_msg_data = memresp_val ? q_data_q[head_q] : 32'd0;
    assign err              = err_q;

    // lane_a documents the naturally aligned lane; the case arms above encode it directly.
    logic unused_lane_a;
    assign unused_lane_a = ^lane_a;
endmodule
